// File: rtl/complementer_pkg.sv
// Shared encodings for the digit-serial add/sub/negate unit:
// operation codes carried on the op port and the control FSM states.
package complementer_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_NEG  = 2'b10,
        OP_ADDC = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/digit_rca.sv
// Combinational ripple of DIGIT full adders. c_msb is the carry into the
// top bit of the slice, which on the final digit is the carry into the
// word MSB and feeds the signed overflow flag.
module digit_rca #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    // Ripple the carry through each bit of the slice.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_complementer.sv
// Digit-serial two's-complement ADD / SUB / NEG / ADDC unit with a
// valid/ready handshake on both sides. DIGIT bits are summed per cycle, so a
// result takes WIDTH/DIGIT cycles. Optional build macro SERIAL_ADDSUB_SAT_EN
// clamps S to the signed extreme on overflow (Cout/Ovf stay raw).
module serial_addsub_complementer
    import complementer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_addsub_complementer: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [WIDTH-1:0]      x_sh;
    logic [WIDTH-1:0]      y_sh;
    logic [WIDTH-1:0]      res;
    logic                  carry;

    logic [DIGIT-1:0]      dsum;
    logic                  dcout;
    logic                  dcmsb;
    logic [WIDTH-1:0]      res_next;
    logic [WIDTH-1:0]      s_final;
    logic                  ovf_now;
    logic                  last;

    digit_rca #(.DIGIT(DIGIT)) u_rca (
        .x     (x_sh[DIGIT-1:0]),
        .y     (y_sh[DIGIT-1:0]),
        .cin   (carry),
        .sum   (dsum),
        .cout  (dcout),
        .c_msb (dcmsb)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (cnt == CW'(N - 1));
    assign ovf_now   = dcout ^ dcmsb;
    // New digit enters from the MSB side; oldest digits drift toward bit 0.
    assign res_next  = WIDTH'({dsum, res} >> DIGIT);

`ifdef SERIAL_ADDSUB_SAT_EN
    // Signed extreme in the direction of the operand sign (X MSB).
    function automatic logic [WIDTH-1:0] sat_clamp(input logic x_msb);
        logic signed [WIDTH-1:0] lim;
        lim = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return lim;
    endfunction

    // On the last digit the low slice of x_sh holds the top bits of X.
    assign s_final = ovf_now ? sat_clamp(x_sh[DIGIT-1]) : res_next;
`else
    assign s_final = res_next;
`endif

    // Control FSM, digit counter and registered result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        S     <= s_final;
                        Cout  <= dcout;
                        Ovf   <= ovf_now;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand mapping at accept, then digit-wise shifting while running.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            x_sh  <= (op == OP_NEG) ? '0 : A;
            case (op)
                OP_SUB:  y_sh <= ~B;
                OP_NEG:  y_sh <= ~A;
                default: y_sh <= B;
            endcase
            carry <= (op != OP_ADD);
        end else if (state == RUN) begin
            x_sh  <= x_sh >> DIGIT;
            y_sh  <= y_sh >> DIGIT;
            carry <= dcout;
            res   <= res_next;
        end
    end

endmodule

// File: tb/tb_serial_addsub_complementer.sv
// Self-checking bench for serial_addsub_complementer at WIDTH=8. The DIGIT
// parameter selects the slice width; SERIAL_ADDSUB_SAT_EN selects the
// saturating expectations.
module tb_serial_addsub_complementer;

    parameter int DIGIT = 1;
    localparam int W = 8;
    localparam int N = W / DIGIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [1:0] op = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] S;
    logic       Cout;
    logic       Ovf;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   pending = 1'b0;
    logic prev_ov = 1'b0;
    logic [7:0] exp_s = 8'h00;
    logic       exp_c = 1'b0;
    logic       exp_o = 1'b0;

    always #5 clk = ~clk;

    serial_addsub_complementer #(.WIDTH(W), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
        int sa, sb, u, tru;
        logic [7:0] s;
        logic c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (o)
            2'd0: begin u = int'(a) + int'(b);         tru = sa + sb;     end
            2'd1: begin u = int'(a) + 256 - int'(b);   tru = sa - sb;     end
            2'd2: begin u = 256 - int'(a);             tru = -sa;         end
            default: begin u = int'(a) + int'(b) + 1; tru = sa + sb + 1; end
        endcase
        s = u[7:0];
        c = (u >= 256);
        v = (tru > 127) || (tru < -128);
`ifdef SERIAL_ADDSUB_SAT_EN
        if (tru > 127)  s = 8'h7F;
        if (tru < -128) s = 8'h80;
`endif
        return {v, c, s};
    endfunction

    // Output checker: result fields, latency and in_ready while a result is
    // expected; out_valid must stay low otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pending) begin
                if (out_valid) begin
                    if (!prev_ov) chk("latency", cyc - acc_cyc, N);
                    chk("S", S, exp_s);
                    chk("Cout", Cout, exp_c);
                    chk("Ovf", Ovf, exp_o);
                    chk("in_ready_busy", in_ready, 1'b0);
                end
            end else begin
                chk("idle_out_valid", out_valid, 1'b0);
            end
        end
        prev_ov <= out_valid;
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
        A = a; B = b; op = o; in_valid = 1'b1;
        {exp_o, exp_c, exp_s} = model(a, b, o);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        pending = 1'b1;
        // Operands and in_valid are don't-care once accepted.
        in_valid = 1'($urandom % 2);
        A = 8'($urandom); B = 8'($urandom); op = 2'($urandom);
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o, input int hold);
        int k;
        wait_ready();
        accept(a, b, o);
        k = 0;
        while (!out_valid && k < N + 5) begin
            @(negedge clk);
            k++;
        end
        chk("out_valid_arrive", out_valid, 1'b1);
        repeat (hold) @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        pending = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after", in_ready, 1'b1);
    endtask

`ifdef SERIAL_ADDSUB_SAT_EN
    localparam logic [9:0] P_NEG80 = 10'h27F;
    localparam logic [9:0] P_7F01  = 10'h27F;
    localparam logic [9:0] P_80FF  = 10'h380;
`else
    localparam logic [9:0] P_NEG80 = 10'h280;
    localparam logic [9:0] P_7F01  = 10'h280;
    localparam logic [9:0] P_80FF  = 10'h37F;
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-computed pins on the reference model, format {Ovf,Cout,S}.
        chk("pin_add_0c_03",  model(8'h0C, 8'h03, 2'd0), 10'h00F);
        chk("pin_sub_05_07",  model(8'h05, 8'h07, 2'd1), 10'h0FE);
        chk("pin_sub_07_05",  model(8'h07, 8'h05, 2'd1), 10'h102);
        chk("pin_addc_0e_01", model(8'h0E, 8'h01, 2'd3), 10'h010);
        chk("pin_neg_01",     model(8'h01, 8'h00, 2'd2), 10'h0FF);
        chk("pin_neg_80",     model(8'h80, 8'h00, 2'd2), P_NEG80);
        chk("pin_add_7f_01",  model(8'h7F, 8'h01, 2'd0), P_7F01);
        chk("pin_add_80_ff",  model(8'h80, 8'hFF, 2'd0), P_80FF);
        chk("pin_add_ff_01",  model(8'hFF, 8'h01, 2'd0), 10'h100);

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_S", S, 8'h00);
        chk("rst_Cout", Cout, 1'b0);
        chk("rst_Ovf", Ovf, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);

        // Directed cases.
        run_txn(8'h0C, 8'h03, 2'd0, 0);
        run_txn(8'h05, 8'h07, 2'd1, 1);
        run_txn(8'h07, 8'h05, 2'd1, 0);
        run_txn(8'h0E, 8'h01, 2'd3, 0);
        run_txn(8'h01, 8'h5A, 2'd2, 0);
        run_txn(8'h80, 8'h33, 2'd2, 0);
        run_txn(8'h7F, 8'h01, 2'd0, 0);
        run_txn(8'h80, 8'hFF, 2'd0, 0);
        run_txn(8'hFF, 8'h01, 2'd0, 0);
        // Backpressure: result held for 5 cycles with out_ready low.
        run_txn(8'h7F, 8'h01, 2'd0, 5);

        // Reset pulse in the middle of a run: no result may appear.
        wait_ready();
        accept(8'h12, 8'h34, 2'd0);
        in_valid = 1'b0;
        if (N > 2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        pending = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_S", S, 8'h00);
        chk("midrst_Cout", Cout, 1'b0);
        chk("midrst_Ovf", Ovf, 1'b0);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            run_txn(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
